// File: rtl/hv_reg_bank_rsp.sv
// hv_reg_bank_rsp: request/ack register bank with CRC-8 protected responses.
// Twelve config registers (0x00..0x0B), three read-only status bytes
// (0x0C..0x0E) and a rejected-write counter ERR_CNT (0x0F).
// Optional feature macro: HV_REG_WR_CRC_CHK_EN. When it is defined, a write
// is accepted only if its CRC matches. When it is undefined, wcrc is ignored,
// every write is accepted, and ERR_CNT reads as zero.
module hv_reg_bank_rsp #(
    parameter int REG_AW    = 7,
    parameter int REG_DW    = 8,
    parameter int REG_CRC_W = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_rac_reg_ren,
    input  logic                   i_rac_reg_wen,
    input  logic [REG_AW-1:0]      i_rac_reg_addr,
    input  logic [REG_DW-1:0]      i_rac_reg_wdata,
    input  logic [REG_CRC_W-1:0]   i_rac_reg_wcrc,
    input  logic [3*REG_DW-1:0]    i_sts_data,
    output logic                   o_reg_rac_wack,
    output logic                   o_reg_rac_rack,
    output logic [REG_DW-1:0]      o_reg_rac_rdata,
    output logic [REG_CRC_W-1:0]   o_reg_rac_rcrc,
    output logic [12*REG_DW-1:0]   o_cfg_regs,
    output logic                   o_crc_err
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ACK, S_WAIT_REL} state_t;

    localparam logic [REG_AW-1:0]    A_ERR    = REG_AW'(15);
    localparam logic [REG_CRC_W-1:0] CRC_POLY = REG_CRC_W'(8'h07);

    // Bit-serial CRC-8, MSB first, init 0, no reflection, no final XOR.
    function automatic logic [REG_CRC_W-1:0] crc_calc(input logic [REG_AW+REG_DW-1:0] d);
        logic [REG_CRC_W-1:0] c;
        logic                 fb;
        c = '0;
        for (int i = REG_AW+REG_DW-1; i >= 0; i--) begin
            fb = c[REG_CRC_W-1] ^ d[i];
            c  = {c[REG_CRC_W-2:0], 1'b0};
            if (fb) c = c ^ CRC_POLY;
        end
        return c;
    endfunction

    state_t                  state, state_nxt;
    logic                    accept, exec_st, ack_st;
    logic                    cap_wr;
    logic [REG_AW-1:0]       cap_addr;
    logic [REG_DW-1:0]       cap_wdata;
    logic [11:0][REG_DW-1:0] cfg_q;
    logic [2:0][REG_DW-1:0]  sts;
    logic [REG_DW-1:0]       rd_mux, crc_dat;
    logic [REG_CRC_W-1:0]    crc_val;
    logic [7:0]              err_cnt;
    logic                    wr_ok;

    assign sts        = i_sts_data;
    assign o_cfg_regs = cfg_q;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state: one transaction per request; WAIT_REL blocks until both requests drop.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (i_rac_reg_ren || i_rac_reg_wen) state_nxt = S_EXEC;
            S_EXEC:     state_nxt = S_ACK;
            S_ACK:      state_nxt = S_WAIT_REL;
            S_WAIT_REL: if (!i_rac_reg_ren && !i_rac_reg_wen) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // State decode used by the datapath.
    always_comb begin
        accept  = (state == S_IDLE) && (i_rac_reg_ren || i_rac_reg_wen);
        exec_st = (state == S_EXEC);
        ack_st  = (state == S_ACK);
    end

    // Read source select from the captured address; unmapped addresses read zero.
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < 12; k++)
            if (cap_addr == REG_AW'(k)) rd_mux = cfg_q[k];
        for (int k = 0; k < 3; k++)
            if (cap_addr == REG_AW'(12 + k)) rd_mux = sts[k];
        if (cap_addr == A_ERR) rd_mux = REG_DW'(err_cnt);
    end

    // One CRC engine: over the write data for writes, over the read data for reads.
    always_comb begin
        crc_dat = cap_wr ? cap_wdata : rd_mux;
        crc_val = crc_calc({cap_addr, crc_dat});
    end

    // Capture the request; a write wins when both requests are high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cap_wr    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else if (accept) begin
            cap_wr    <= i_rac_reg_wen;
            cap_addr  <= i_rac_reg_addr;
            cap_wdata <= i_rac_reg_wdata;
        end
    end

    // Execute: register write, or registered read data + CRC held until the next read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cfg_q           <= '0;
            o_reg_rac_rdata <= '0;
            o_reg_rac_rcrc  <= '0;
        end else if (exec_st) begin
            if (cap_wr) begin
                for (int k = 0; k < 12; k++)
                    if (wr_ok && cap_addr == REG_AW'(k)) cfg_q[k] <= cap_wdata;
            end else begin
                o_reg_rac_rdata <= rd_mux;
                o_reg_rac_rcrc  <= crc_val;
            end
        end
    end

    // Acks are registered out of ACK so they land two edges after the request is sampled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_reg_rac_wack <= 1'b0;
            o_reg_rac_rack <= 1'b0;
        end else begin
            o_reg_rac_wack <= ack_st && cap_wr;
            o_reg_rac_rack <= ack_st && !cap_wr;
        end
    end

`ifdef HV_REG_WR_CRC_CHK_EN
    logic [REG_CRC_W-1:0] cap_wcrc;

    assign wr_ok = (cap_wcrc == crc_val);

    // Write CRC captured alongside the other request fields.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)    cap_wcrc <= '0;
        else if (accept) cap_wcrc <= i_rac_reg_wcrc;
    end

    // ERR_CNT: saturating count of rejected writes; a read of 0x0F clears it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) err_cnt <= 8'h00;
        else if (exec_st) begin
            if (cap_wr && !wr_ok && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
            else if (!cap_wr && cap_addr == A_ERR)    err_cnt <= 8'h00;
        end
    end

    // CRC error pulse aligned with the write ack; fields are still stable in ACK.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_crc_err <= 1'b0;
        else          o_crc_err <= ack_st && cap_wr && !wr_ok;
    end
`else
    logic unused_wcrc;

    assign unused_wcrc = ^i_rac_reg_wcrc;
    assign wr_ok       = 1'b1;
    assign err_cnt     = 8'h00;
    assign o_crc_err   = 1'b0;
`endif

endmodule

// File: doc/hv_reg_bank_rsp.md
HV_REG_BANK_RSP -- requirements
Module: hv_reg_bank_rsp

Interface
REQ-001 SHALL provide parameter REG_AW, default 7, register address width.
REQ-002 SHALL provide parameter REG_DW, default 8, register data width.
REQ-003 SHALL provide parameter REG_CRC_W, default 8, CRC width (CRC-8 only).
REQ-004 SHALL have i_clk  input  1  clock; all sequential logic on its rising edge.
REQ-005 SHALL have i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have i_rac_reg_ren  input  1  read request, level, held by requester until ack.
REQ-007 SHALL have i_rac_reg_wen  input  1  write request, level, held by requester until ack.
REQ-008 SHALL have i_rac_reg_addr  input  REG_AW  access address.
REQ-009 SHALL have i_rac_reg_wdata  input  REG_DW  write data.
REQ-010 SHALL have i_rac_reg_wcrc  input  REG_CRC_W  write CRC.
REQ-011 SHALL have i_sts_data  input  3*REG_DW  read-only status; byte k maps to address 0x0C+k.
REQ-012 SHALL have o_reg_rac_wack  output  1  write ack, one-cycle pulse.
REQ-013 SHALL have o_reg_rac_rack  output  1  read ack, one-cycle pulse.
REQ-014 SHALL have o_reg_rac_rdata  output  REG_DW  read data.
REQ-015 SHALL have o_reg_rac_rcrc  output  REG_CRC_W  read CRC.
REQ-016 SHALL have o_cfg_regs  output  12*REG_DW  config registers 0x00..0x0B; byte k = address k.
REQ-017 SHALL have o_crc_err  output  1  one-cycle pulse on a rejected write.

Function
REQ-018 SHALL implement FSM IDLE, EXEC, ACK, WAIT_REL.
REQ-019 IDLE: ren|wen high -> capture addr/wdata/wcrc/op, go EXEC; wen wins when both high.
REQ-020 EXEC: compute CRC, perform write or select read data, go ACK.
REQ-021 ACK: assert exactly one of wack/rack for one cycle with rdata/rcrc valid that cycle, go WAIT_REL.
REQ-022 WAIT_REL: hold until ren and wen both low, then IDLE; no request accepted meanwhile.
REQ-023 Latency: request sampled at edge T -> ack high from edge T+2 to T+3.
REQ-024 CRC-8: poly 0x07, init 0x00, no reflection, no final XOR, over {addr,data} (REG_AW+REG_DW bits), MSB first.
REQ-025 Accepted write to 0x00..0x0B updates the register on the EXEC->ACK edge; o_cfg_regs reflects it from that edge.
REQ-026 Write to 0x0C..0x0F or 0x10..0x7F: no state change, wack still issued, no o_crc_err.
REQ-027 Read data: config reg (0x00..0x0B), status byte (0x0C..0x0E), ERR_CNT (0x0F), 0x00 otherwise; rcrc = CRC over {captured addr, rdata}.
REQ-028 rdata/rcrc registered, stable from ACK until the next read's ACK.
REQ-029 ERR_CNT 8-bit: +1 per rejected write, saturates at 0xFF; a read of 0x0F returns the pre-clear value and clears it.
REQ-030 Rejected write still gets wack; o_crc_err pulses in the same cycle as wack.
REQ-031 Request dropping before ack does not abort; the transaction completes and acks.

Reset
REQ-032 i_rst_n low: state IDLE; wack/rack/crc_err 0; rdata/rcrc 0x00; all cfg regs 0x00; ERR_CNT 0x00; captured fields 0.
REQ-033 Reset mid-transaction aborts with no ack; a request still high after release is a new transaction.

Configuration
REQ-034 HV_REG_WR_CRC_CHK_EN defined: write accepted only if i_rac_reg_wcrc equals CRC over {addr,wdata}; mismatch -> rejected per REQ-029/030.
REQ-035 HV_REG_WR_CRC_CHK_EN undefined: wcrc ignored, all writes accepted, o_crc_err tied 0, ERR_CNT reads 0x00.

Verification
REQ-036 Write addr 0x03 data 0xA5 correct CRC -> wack at T+2, o_cfg_regs byte3 = 0xA5, o_crc_err 0.
REQ-037 (CHK_EN) Write 0x05 data 0x3C CRC^0x01 -> wack + o_crc_err same cycle, byte5 stays 0x00; read 0x0F -> 0x01; reread -> 0x00.
REQ-038 i_sts_data byte1 = 0x7E, read 0x0D -> rack, rdata 0x7E, rcrc = CRC8({7'h0D,8'h7E}); read 0x40 -> rdata 0x00.
REQ-039 ren held 5 cycles past ack -> exactly one rack; ren+wen together at 0x02 data 0x11 -> wack only, reg 0x02 = 0x11.
REQ-040 Reset pulse during EXEC of write 0x01 data 0xFF -> no ack, reg 0x01 = 0x00; (CHK_EN) 256 bad writes -> ERR_CNT = 0xFF.
